// File: rtl/flit_injector.sv
// flit_injector: credit-based flit injector feeding one router input port.
// Accepts flits from a client through a valid/ready handshake. Each flit is
// forwarded one cycle later on channel_out. One credit counter is kept per
// virtual channel, and credits come back through flow_ctrl_in.
// Optional feature macro: FLIT_INJECTOR_ERROR_CHECK_EN. When it is defined,
// the module detects packet framing violations and credit overflow and
// reports them on a sticky error flag. When it is undefined, error is tied
// to 0.
module flit_injector #(
  parameter int BUFFER_SIZE = 8,
  parameter int NUM_VCS     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flit_valid,
  output logic          flit_ready,
  input  logic          flit_head,
  input  logic          flit_tail,
  input  logic          flit_vc,
  input  logic [0:63]   flit_data,
  output logic [0:67]   channel_out,
  input  logic [0:1]    flow_ctrl_in,
  output logic          error
);

  // The flit_vc and flow_ctrl_in VC fields are one bit wide, so only two
  // virtual channels can be addressed. Credit counters are four bits wide.
  if (NUM_VCS != 2) begin : g_bad_num_vcs
    $error("flit_injector: NUM_VCS must be 2");
  end
  if (BUFFER_SIZE < 1 || BUFFER_SIZE > 15) begin : g_bad_buffer_size
    $error("flit_injector: BUFFER_SIZE must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } pkt_state_t;

  localparam logic [3:0] CREDIT_MAX = 4'(BUFFER_SIZE);

  logic [3:0]         credit    [NUM_VCS];
  pkt_state_t         pkt_state [NUM_VCS];
  logic               xfer;
  logic [NUM_VCS-1:0] take;
  logic [NUM_VCS-1:0] give;
  logic [NUM_VCS-1:0] at_max;

  // Offer a slot whenever the target VC has a credit. This does not depend
  // on flit_valid. It is held off while reset is high.
  always_comb begin
    flit_ready = 1'b0;
    if (!reset) begin
      flit_ready = (credit[flit_vc] != 4'd0);
    end
    xfer = flit_valid && flit_ready;
  end

  // Decode per-VC events: a flit consumed, a credit returned, and whether
  // the counter already holds the full buffer depth.
  always_comb begin
    take   = '0;
    give   = '0;
    at_max = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      take[v]   = xfer && (flit_vc == 1'(v));
      give[v]   = flow_ctrl_in[0] && (flow_ctrl_in[1] == 1'(v));
      at_max[v] = (credit[v] == CREDIT_MAX);
    end
  end

  // Credit bookkeeping. A simultaneous take and give cancel out. A return
  // into a full counter is dropped, so the counter saturates at BUFFER_SIZE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credit[v] <= CREDIT_MAX;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (take[v] && !give[v]) begin
          credit[v] <= credit[v] - 4'd1;
        end else if (give[v] && !take[v] && !at_max[v]) begin
          credit[v] <= credit[v] + 4'd1;
        end
      end
    end
  end

  // Per-VC packet framing tracker. It advances only on flits sent to its
  // own VC. A malformed flit still moves the state according to its
  // head and tail bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        pkt_state[v] <= IDLE;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (take[v]) begin
          case (pkt_state[v])
            IDLE: if (flit_head && !flit_tail) pkt_state[v] <= BODY;
            BODY: if (flit_tail) pkt_state[v] <= IDLE;
            default: pkt_state[v] <= IDLE;
          endcase
        end
      end
    end
  end

  // Register the outgoing channel word. It carries the accepted flit
  // unchanged, with the valid bit set. When no flit is accepted, the word
  // is all zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      channel_out <= '0;
    end else if (xfer) begin
      channel_out <= {1'b1, flit_head, flit_tail, flit_vc, flit_data};
    end else begin
      channel_out <= '0;
    end
  end

`ifdef FLIT_INJECTOR_ERROR_CHECK_EN
  logic [NUM_VCS-1:0] overflow;
  logic [NUM_VCS-1:0] violation;
  logic               error_q;

  // Flag a credit returned into a full counter, and any flit whose head
  // bit disagrees with the packet state of its VC.
  always_comb begin
    overflow  = '0;
    violation = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      overflow[v]  = give[v] && !take[v] && at_max[v];
      violation[v] = take[v] &&
                     (((pkt_state[v] == IDLE) && !flit_head) ||
                      ((pkt_state[v] == BODY) &&  flit_head));
    end
  end

  // Sticky error latch. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if ((|overflow) || (|violation)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter: BUFFER_SIZE, default 8, router input buffer depth per VC (credits per VC); legal range 1..15.
REQ-002 Parameter: NUM_VCS, fixed 2, virtual channels per router port; any other value is illegal.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: flit_valid  input  1  client presents a flit.
REQ-006 Port: flit_ready  output  1  injector accepts the presented flit this cycle.
REQ-007 Port: flit_head  input  1  presented flit is a packet head.
REQ-008 Port: flit_tail  input  1  presented flit is a packet tail.
REQ-009 Port: flit_vc  input  1  target VC of the presented flit.
REQ-010 Port: flit_data  input  [0:63]  flit payload.
REQ-011 Port: channel_out  output  [0:67]  router input channel: bit 0 valid, bit 1 head, bit 2 tail, bit 3 VC, bits 4..67 payload.
REQ-012 Port: flow_ctrl_in  input  [0:1]  credit return from router: bit 0 credit valid, bit 1 VC.
REQ-013 Port: error  output  1  sticky protocol/credit error flag.

Function
REQ-014 One credit counter per VC, width 4, range 0..BUFFER_SIZE.
REQ-015 flit_ready = (credit[flit_vc] != 0), combinational on flit_vc; not gated by flit_valid.
REQ-016 Transfer occurs when flit_valid && flit_ready.
REQ-017 Latency: a flit transferred in cycle N appears on channel_out in cycle N+1 with bit 0 = 1 and fields copied unchanged.
REQ-018 No transfer in cycle N: channel_out = all zeros in cycle N+1.
REQ-019 Credit update per VC each cycle: +1 on credit return to that VC, -1 on transfer on that VC; both together leaves the counter unchanged.
REQ-020 Credits returned in cycle N take effect on flit_ready in cycle N+1, never in cycle N.
REQ-021 Credit return to a VC at BUFFER_SIZE with no simultaneous transfer on that VC: counter holds at BUFFER_SIZE and error is set.
REQ-022 Per-VC packet FSM, states IDLE and BODY, advancing only on transfers to that VC.
REQ-023 IDLE -> BODY on head=1, tail=0; head=1, tail=1 stays IDLE.
REQ-024 BODY -> IDLE on tail=1; BODY stays BODY on tail=0.
REQ-025 A head=0 transfer in IDLE, or a head=1 transfer in BODY, sets error.
REQ-026 A violating flit is still forwarded and the FSM still advances per REQ-023/024 using its head/tail bits.
REQ-027 Flits on VC0 and VC1 interleave at flit granularity; each VC's FSM is independent.
REQ-028 Once set, error stays 1 until reset.

Reset
REQ-029 On reset: credit counters = BUFFER_SIZE, FSMs = IDLE, channel_out = 0, error = 0.
REQ-030 Reset mid-packet abandons the packet; no tail is generated.
REQ-031 While reset is high, flit_ready = 0 and all transfers and credit returns are ignored.

Configuration
REQ-032 Macro FLIT_INJECTOR_ERROR_CHECK_EN defined: error behaves per REQ-021, REQ-025 and REQ-028.
REQ-033 Macro not defined: error is constant 0, violation-detection logic is absent, and all other behaviour is identical.

Verification
REQ-034 BUFFER_SIZE=8, 8 head/tail flits on VC0, no credits -> 8 transfers, flit_ready=0 for VC0 afterwards, VC1 still ready.
REQ-035 Credit counter for VC1 at 0, then flow_ctrl_in=2'b11 in cycle N -> flit_ready for VC1 = 0 in N and 1 in N+1.
REQ-036 Transfer on VC0 and VC0 credit return in the same cycle with counter=3 -> counter stays 3.
REQ-037 Head on VC0 in cycle 1, then data 0xA5A5_A5A5_A5A5_A5A5 with head=1 on VC0 in cycle 2 -> flit forwarded in cycle 3 and error=1 from cycle 3.
REQ-038 Credit return to VC0 while counter=8 -> counter holds at 8, error=1 (macro defined) or error=0 (macro undefined).
REQ-039 Reset asserted mid-packet on VC1 -> next cycle channel_out=0, counters=8, head flit on VC1 accepted without error.
